q2_sequencer: RTL
=================

// Module: q2_sequencer
// PURPOSE
// - Micro-state sequencer for the Q2 CPU: generates state bits s0..s3 and write strobe ws consumed by q2_control.
// - Each micro-state lasts two clocks: settle phase (ws=0) then strobe phase (ws=1); next state is chosen at the end of the strobe.
// - Owns run/stop/single-step control from front-panel switches.
// - Stops on the halt strobe from q2_control.
// PARAMETERS
// ALU_STEPS   3   ALU micro-states per ALU instruction (legal 1..3; encoded in {s3,s2})
// START_RUN   0   1: running flag set on reset release; 0: machine starts stopped
// PORTS
// clk       in   1  system clock
// rst       in   1  asynchronous, active-high reset
// op1       in   1  opcode bit 1 (indirect): deref cycle required
// op2       in   1  opcode bit 2 (operand load cycle required)
// op5       in   1  opcode bit 5 (0 = ALU class instruction)
// halt      in   1  halt strobe from q2_control (EXEC, ws=1)
// run_sw    in   1  asynchronous level switch; rising edge sets running
// stop_sw   in   1  asynchronous level switch; rising edge clears running at next FETCH
// step_sw   in   1  asynchronous level switch; rising edge executes one instruction when stopped
// s0,s1,s2,s3 out 1 each  micro-state bits to q2_control
// ws        out  1  write strobe; high only in strobe phase while advancing
// running   out  1  run indicator for the front panel
// BEHAVIOUR
// - Reset (async): {s3,s2,s1,s0}=0000 (FETCH), ws=0, running=START_RUN, step pending=0, synchronizers cleared.
// - Encodings {s3..s0}: FETCH 0000, LOAD 0001, DEREF 0010, EXEC 0011, ALU1 0100, ALU2 1000, ALU3 1100.
// - Advance enable: go = running | step_pending. State and phase are frozen only while in FETCH settle phase with go=0.
//   In that frozen case ws=0. All other states always complete.
// - Phase: settle -> strobe -> next state settle. ws is registered; it is high exactly in the strobe cycle.
// - Transitions (evaluated on strobe cycle, using op bits valid then):
//   FETCH -> LOAD if op2; else DEREF if op1; else EXEC.
//   LOAD  -> DEREF if op1; else EXEC.
//   DEREF -> EXEC.
//   EXEC  -> ALU1 if op5=0; else FETCH.
//   ALUn  -> ALU(n+1) if n<ALU_STEPS; else FETCH.
// - op bits are sampled by the sequencer only on the FETCH strobe cycle (same edge that loads the opcode).
//   Branch decisions use the registered copy. EXEC therefore sees the post-fetch opcode.
// - halt=1 on EXEC strobe: clears running and step_pending; sequencer still goes to FETCH and freezes there.
// - Switches: each passes a 2-flop synchronizer, then a rising-edge detector. Each edge produces a one-clock pulse.
//   run pulse: running<=1.
//   stop pulse: running<=0; the current instruction completes and the machine stops in FETCH settle.
//   step pulse: if running=0 and in FETCH settle, step_pending<=1. Ignored otherwise.
//   step_pending clears on the FETCH strobe cycle, so exactly one instruction executes.
// - Simultaneous events: stop beats run in the same cycle; halt beats run in the same cycle.
//   A held level produces no repeat pulse.
// - Reset mid-instruction: immediate return to FETCH settle with ws=0; no partial strobe is emitted.
// STRUCTURE
// - Shared package q2_pkg:
//   - state encoding constants ST_FETCH, ST_LOAD, ST_DEREF, ST_EXEC, ST_ALU1..ST_ALU3 (4-bit)
//   - phase constants PH_SETTLE, PH_STROBE
// - One sub-module q2_sync_edge:
//   - 2-flop synchronizer plus rising-edge pulse, async reset to 0
//   - instantiated 3x (run, stop, step)
// - Top holds: state reg, phase reg, latched op bits, running, step_pending.
// TESTING
// - Reset, then run pulse, with op=LOAD|ALU (op2=1, op1=0, op5=0), ALU_STEPS=3:
//   state sequence 0000,0001,0011,0100,1000,1100,0000, each 2 clocks, ws high on every second clock.
// - Indirect jump (op1=1, op2=0, op5=1): states FETCH, DEREF, EXEC, FETCH; 6 clocks per instruction.
// - halt asserted during EXEC strobe: running falls next edge; state holds 0000 and ws stays 0 for 20 clocks.
//   A later run pulse resumes.
// - Stopped machine, step pulse with op5=1, op1=op2=0:
//   one FETCH/EXEC pair (4 clocks, 2 ws pulses), then frozen. A second step repeats this exactly once.
// - stop pulse during ALU2: ALU3 and FETCH-bound transition complete, then freeze in FETCH; running=0.
// - Async rst asserted mid ALU1 strobe: outputs 0000, ws=0 immediately (no clock).
//   running=START_RUN after release.

Source files
------------

// File: rtl/q2_pkg.sv
// Shared encodings for the Q2 micro-state sequencer and its consumers.
package q2_pkg;

  typedef enum logic [3:0] {
    ST_FETCH = 4'b0000,
    ST_LOAD  = 4'b0001,
    ST_DEREF = 4'b0010,
    ST_EXEC  = 4'b0011,
    ST_ALU1  = 4'b0100,
    ST_ALU2  = 4'b1000,
    ST_ALU3  = 4'b1100
  } q2_state_e;

  typedef enum logic {
    PH_SETTLE = 1'b0,
    PH_STROBE = 1'b1
  } q2_phase_e;

  // Only the bits that steer branches after FETCH need a held copy.
  typedef struct packed {
    logic op1;
    logic op5;
  } q2_op_t;

  // ALU step index lives in {s3,s2}; step n+1 is the next count in that field.
  function automatic q2_state_e alu_next(logic [1:0] n);
    return q2_state_e'({n + 2'd1, 2'b00});
  endfunction

endpackage

// File: rtl/q2_sequencer_if.sv
// Sequencer <-> control/front-panel signal bundle.
interface q2_sequencer_if;
  logic op1, op2, op5, halt;
  logic run_sw, stop_sw, step_sw;
  logic s0, s1, s2, s3, ws, running;

  modport master (
    input  op1, op2, op5, halt, run_sw, stop_sw, step_sw,
    output s0, s1, s2, s3, ws, running
  );

  modport slave (
    output op1, op2, op5, halt, run_sw, stop_sw, step_sw,
    input  s0, s1, s2, s3, ws, running
  );
endinterface

// File: rtl/q2_sync_edge.sv
// Two-flop synchronizer for a panel switch followed by a rising-edge pulse.
module q2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic pulse
);
  // sh[1:0] is the synchronizer, sh[2] remembers the previous synced level.
  logic [2:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh <= '0;
    else     sh <= {sh[1:0], sw};
  end

  assign pulse = sh[1] & ~sh[2];
endmodule

// File: rtl/q2_sequencer.sv
// Q2 micro-state sequencer: two-clock micro-states (settle, strobe) with
// run/stop/single-step control and halt handling.
module q2_sequencer
  import q2_pkg::*;
#(
  parameter int ALU_STEPS = 3,
  parameter bit START_RUN = 1'b0
) (
  input logic            clk,
  input logic            rst,
  q2_sequencer_if.master bus
);

  logic run_pulse, stop_pulse, step_pulse;

  q2_sync_edge u_run  (.clk(clk), .rst(rst), .sw(bus.run_sw),  .pulse(run_pulse));
  q2_sync_edge u_stop (.clk(clk), .rst(rst), .sw(bus.stop_sw), .pulse(stop_pulse));
  q2_sync_edge u_step (.clk(clk), .rst(rst), .sw(bus.step_sw), .pulse(step_pulse));

  q2_state_e state_q, state_d;
  q2_phase_e phase_q, phase_d;
  q2_op_t    op_q;
  logic      running_q, running_d;
  logic      step_q, step_d;

  logic go, fetch_settle, fetch_strobe, halt_hit;

  assign go           = running_q | step_q;
  assign fetch_settle = (state_q == ST_FETCH) && (phase_q == PH_SETTLE);
  assign fetch_strobe = (state_q == ST_FETCH) && (phase_q == PH_STROBE);
  assign halt_hit     = (state_q == ST_EXEC) && (phase_q == PH_STROBE) && bus.halt;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    running_d = running_q;
    step_d    = step_q;

    if (phase_q == PH_SETTLE) begin
      // Only FETCH settle can stall; every other micro-state runs to completion.
      if (state_q != ST_FETCH || go) phase_d = PH_STROBE;
    end else begin
      phase_d = PH_SETTLE;
      unique case (state_q)
        // FETCH branches on the live opcode: it is loaded on this same edge.
        ST_FETCH: state_d = bus.op2 ? ST_LOAD : (bus.op1 ? ST_DEREF : ST_EXEC);
        ST_LOAD:  state_d = op_q.op1 ? ST_DEREF : ST_EXEC;
        ST_DEREF: state_d = ST_EXEC;
        ST_EXEC:  state_d = (op_q.op5 || bus.halt) ? ST_FETCH : ST_ALU1;
        ST_ALU1, ST_ALU2, ST_ALU3:
          state_d = (int'(state_q[3:2]) < ALU_STEPS) ? alu_next(state_q[3:2]) : ST_FETCH;
        default:  state_d = ST_FETCH;
      endcase
    end

    // stop and halt win over a coincident run.
    if (halt_hit || stop_pulse) running_d = 1'b0;
    else if (run_pulse)         running_d = 1'b1;

    if (halt_hit || fetch_strobe)                      step_d = 1'b0;
    else if (step_pulse && !running_q && fetch_settle) step_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      phase_q   <= PH_SETTLE;
      op_q      <= '0;
      running_q <= START_RUN;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      running_q <= running_d;
      step_q    <= step_d;
      if (fetch_strobe) op_q <= '{op1: bus.op1, op5: bus.op5};
    end
  end

  // phase_q is a flop, so ws is registered and clears with reset immediately.
  assign {bus.s3, bus.s2, bus.s1, bus.s0} = state_q;
  assign bus.ws      = (phase_q == PH_STROBE);
  assign bus.running = running_q;

endmodule
